// File: rtl/lvds_link_pkg.sv
// Shared constants for the LVDS link controller: FSM state encodings, word
// tags, the idle word, the default training pattern, and a saturating
// increment helper.
package lvds_link_pkg;

    // Link FSM states
    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_TRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Word tags in bits [9:8] of each 10-bit line word
    localparam logic [1:0] TAG_HI   = 2'b10;
    localparam logic [1:0] TAG_LO   = 2'b01;
    localparam logic [1:0] TAG_IDLE = 2'b00;

    localparam logic [9:0] IDLE_WORD          = {TAG_IDLE, 8'h00};
    localparam logic [9:0] TRAIN_WORD_DEFAULT = 10'h2AA;

    // 8-bit increment that holds at 8'hFF
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lvds_rx_deframer.sv
// Receive deframer: registers datarx, then rebuilds 16-bit samples from
// high/low tagged words. While disabled it discards any partial sample.
// Optional feature macro: LINK_STATS_EN (saturating frame error counter).
module lvds_rx_deframer
    import lvds_link_pkg::*;
(
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [9:0]  datarx,
    output logic [15:0] rx_voltage,
    output logic        rx_voltage_valid,
    output logic [7:0]  frame_err_cnt
);

    logic [9:0]  word_q, word_d;
    logic [7:0]  hi_q, hi_d;
    logic        pend_q, pend_d;
    logic [15:0] rxv_q, rxv_d;
    logic        valid_q, valid_d;
    logic        err;

    // Decode the registered word against the pending high byte
    always_comb begin
        // NOTE: every variable gets a default here so no latch is inferred.
        word_d  = en ? datarx : IDLE_WORD;
        hi_d    = hi_q;
        pend_d  = pend_q;
        rxv_d   = rxv_q;
        valid_d = 1'b0;
        err     = 1'b0;
        if (!en) begin
            pend_d = 1'b0;
        end else begin
            case (word_q[9:8])
                TAG_HI: begin
                    // A second high byte replaces the first one
                    err    = pend_q;
                    hi_d   = word_q[7:0];
                    pend_d = 1'b1;
                end
                TAG_LO: begin
                    if (pend_q) begin
                        rxv_d   = {hi_q, word_q[7:0]};
                        valid_d = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        err = 1'b1;
                    end
                end
                TAG_IDLE: begin
                    if (pend_q) begin
                        err    = 1'b1;
                        pend_d = 1'b0;
                    end
                end
                default: err = 1'b1;
            endcase
        end
    end

    // Deframer state registers
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            word_q  <= IDLE_WORD;
            hi_q    <= 8'h00;
            pend_q  <= 1'b0;
            rxv_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            hi_q    <= hi_d;
            pend_q  <= pend_d;
            rxv_q   <= rxv_d;
            valid_q <= valid_d;
        end
    end

    assign rx_voltage       = rxv_q;
    assign rx_voltage_valid = valid_q;

`ifdef LINK_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    assign err_cnt_d = err ? sat_inc8(err_cnt_q) : err_cnt_q;

    // Saturating frame error counter
    always_ff @(posedge sysclk) begin
        if (!rst_n) err_cnt_q <= 8'h00;
        else        err_cnt_q <= err_cnt_d;
    end

    assign frame_err_cnt = err_cnt_q;
`else
    logic unused_err;
    assign unused_err    = err;
    assign frame_err_cnt = 8'h00;
`endif

endmodule

// File: rtl/lvds_link_ctrl.sv
// LVDS link controller: SYNC/TRAIN/RUN bring-up FSM, one-deep sample holding
// register, high/low byte framer onto datatx, and the receive deframer.
// Optional feature macro: LINK_STATS_EN (saturating overrun/frame error counters).
module lvds_link_ctrl
    import lvds_link_pkg::*;
#(
    parameter int         LOCK_STABLE  = 16,
    parameter int         SYNC_TIMEOUT = 4096,
    parameter int         TRAIN_WORDS  = 8,
    parameter logic [9:0] TRAIN_WORD   = TRAIN_WORD_DEFAULT
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        lock_n,
    input  logic [9:0]  datarx,
    input  logic [15:0] ad_voltage,
    input  logic        ad_voltage_valid,
    output logic [9:0]  datatx,
    output logic        sync_req,
    output logic        link_up,
    output logic        sync_timeout,
    output logic [15:0] rx_voltage,
    output logic        rx_voltage_valid,
    output logic        overrun,
    output logic [7:0]  frame_err_cnt,
    output logic [7:0]  overrun_cnt
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int MW = $clog2(TRAIN_WORDS + 1);
    localparam logic [SW-1:0] STABLE_END  = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(SYNC_TIMEOUT);
    localparam logic [MW-1:0] MATCH_END   = MW'(TRAIN_WORDS);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] stable_q, stable_d, stable_inc;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [MW-1:0] match_q, match_d, match_inc;
    logic [15:0]   hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          hi_sent_q, hi_sent_d;
    logic [9:0]    datatx_q, datatx_d;
    logic          sync_req_q, sync_req_d;
    logic          link_up_q, link_up_d;
    logic          sync_to_q, sync_to_d;
    logic          overrun_q, overrun_d;

    assign stable_inc = stable_q + SW'(1);
    assign timer_inc  = timer_q + TW'(1);
    assign match_inc  = match_q + MW'(1);

    // Next-state, transmitter and registered-output logic
    always_comb begin
        state_d     = state_q;
        stable_d    = stable_q;
        timer_d     = timer_q;
        match_d     = match_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hi_sent_d   = hi_sent_q;
        datatx_d    = IDLE_WORD;
        sync_to_d   = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_SYNC: begin
                timer_d  = timer_inc;
                stable_d = lock_n ? '0 : stable_inc;
                if (!lock_n && stable_inc == STABLE_END) begin
                    state_d  = ST_TRAIN;
                    stable_d = '0;
                    timer_d  = '0;
                    match_d  = '0;
                end else if (timer_inc == TIMEOUT_END) begin
                    sync_to_d = 1'b1;
                    timer_d   = '0;
                    stable_d  = '0;
                end
            end
            ST_TRAIN: begin
                if (lock_n) begin
                    state_d = ST_SYNC;
                end else if (datarx == TRAIN_WORD) begin
                    match_d = match_inc;
                    if (match_inc == MATCH_END) state_d = ST_RUN;
                end else begin
                    match_d = '0;
                end
            end
            ST_RUN: begin
                if (lock_n) begin
                    // Lock lost: drop whatever was waiting to go out
                    state_d     = ST_SYNC;
                    hold_full_d = 1'b0;
                    hi_sent_d   = 1'b0;
                end else begin
                    if (hi_sent_q) begin
                        datatx_d    = {TAG_LO, hold_q[7:0]};
                        hi_sent_d   = 1'b0;
                        hold_full_d = 1'b0;
                    end else if (hold_full_q) begin
                        hi_sent_d = 1'b1;
                        if (ad_voltage_valid) begin
                            // Overrun: newest sample wins, send its high byte now
                            overrun_d = 1'b1;
                            hold_d    = ad_voltage;
                            datatx_d  = {TAG_HI, ad_voltage[15:8]};
                        end else begin
                            datatx_d = {TAG_HI, hold_q[15:8]};
                        end
                    end
                    // Capture into an empty register or one being freed this cycle
                    if (ad_voltage_valid && (!hold_full_q || hi_sent_q)) begin
                        hold_d      = ad_voltage;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (state_d == ST_TRAIN) datatx_d = TRAIN_WORD;
        sync_req_d = (state_d == ST_SYNC);
        link_up_d  = (state_d == ST_RUN);
    end

    // Controller state and output registers
    always_ff @(posedge sysclk) begin
        // NOTE: every flop, the holding register included, is reset so outputs start defined.
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            stable_q    <= '0;
            timer_q     <= '0;
            match_q     <= '0;
            hold_q      <= 16'h0000;
            hold_full_q <= 1'b0;
            hi_sent_q   <= 1'b0;
            datatx_q    <= IDLE_WORD;
            sync_req_q  <= 1'b1;
            link_up_q   <= 1'b0;
            sync_to_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stable_q    <= stable_d;
            timer_q     <= timer_d;
            match_q     <= match_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hi_sent_q   <= hi_sent_d;
            datatx_q    <= datatx_d;
            sync_req_q  <= sync_req_d;
            link_up_q   <= link_up_d;
            sync_to_q   <= sync_to_d;
            overrun_q   <= overrun_d;
        end
    end

    assign datatx       = datatx_q;
    assign sync_req     = sync_req_q;
    assign link_up      = link_up_q;
    assign sync_timeout = sync_to_q;
    assign overrun      = overrun_q;

`ifdef LINK_STATS_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    assign ovr_cnt_d = overrun_d ? sat_inc8(ovr_cnt_q) : ovr_cnt_q;

    // Saturating overrun counter
    always_ff @(posedge sysclk) begin
        if (!rst_n) ovr_cnt_q <= 8'h00;
        else        ovr_cnt_q <= ovr_cnt_d;
    end

    assign overrun_cnt = ovr_cnt_q;
`else
    assign overrun_cnt = 8'h00;
`endif

    // Deframer runs only in RUN while lock is held
    lvds_rx_deframer u_deframer (
        .sysclk           (sysclk),
        .rst_n            (rst_n),
        .en               (link_up_q & ~lock_n),
        .datarx           (datarx),
        .rx_voltage       (rx_voltage),
        .rx_voltage_valid (rx_voltage_valid),
        .frame_err_cnt    (frame_err_cnt)
    );

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Directed testbench for lvds_link_ctrl: bring-up, SYNC timeout, loopback
// framing, overrun, deframer errors and lock loss in RUN.
module tb_lvds_link_ctrl;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        lock_n;
    logic [9:0]  datarx;
    logic [15:0] ad_voltage;
    logic        ad_voltage_valid;
    logic [9:0]  datatx;
    logic        sync_req;
    logic        link_up;
    logic        sync_timeout;
    logic [15:0] rx_voltage;
    logic        rx_voltage_valid;
    logic        overrun;
    logic [7:0]  frame_err_cnt;
    logic [7:0]  overrun_cnt;

    logic        loop_en;
    logic [9:0]  inj_word;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

`ifdef LINK_STATS_EN
    localparam logic [7:0] EXP_OVR_1 = 8'd1;
    localparam logic [7:0] EXP_ERR_1 = 8'd1;
    localparam logic [7:0] EXP_ERR_2 = 8'd2;
`else
    localparam logic [7:0] EXP_OVR_1 = 8'd0;
    localparam logic [7:0] EXP_ERR_1 = 8'd0;
    localparam logic [7:0] EXP_ERR_2 = 8'd0;
`endif

    always #5 sysclk = ~sysclk;

    assign datarx = loop_en ? datatx : inj_word;

    lvds_link_ctrl dut (
        .sysclk           (sysclk),
        .rst_n            (rst_n),
        .lock_n           (lock_n),
        .datarx           (datarx),
        .ad_voltage       (ad_voltage),
        .ad_voltage_valid (ad_voltage_valid),
        .datatx           (datatx),
        .sync_req         (sync_req),
        .link_up          (link_up),
        .sync_timeout     (sync_timeout),
        .rx_voltage       (rx_voltage),
        .rx_voltage_valid (rx_voltage_valid),
        .overrun          (overrun),
        .frame_err_cnt    (frame_err_cnt),
        .overrun_cnt      (overrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge (outputs settled, inputs safe to change)
    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic apply_reset(input logic lock_level);
        rst_n = 1'b0;
        lock_n = lock_level;
        ad_voltage_valid = 1'b0;
        ad_voltage = 16'h0000;
        loop_en = 1'b1;
        inj_word = 10'h000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int pulse_cnt;
    int first_pulse;
    int second_pulse;
    int up_seen;
    int valid_seen;

    initial begin
        apply_reset(1'b1);

        // Reset state
        check("rst_sync_req", sync_req, 1);
        check("rst_datatx", datatx, 10'h000);
        check("rst_link_up", link_up, 0);
        check("rst_sync_timeout", sync_timeout, 0);
        check("rst_rx_voltage", rx_voltage, 16'h0000);
        check("rst_rx_valid", rx_voltage_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overrun_cnt", overrun_cnt, 8'h00);
        check("rst_frame_err_cnt", frame_err_cnt, 8'h00);

        // SYNC timeout with lock_n held high
        pulse_cnt = 0; first_pulse = 0; second_pulse = 0; up_seen = 0;
        for (int c = 1; c <= 8200; c++) begin
            tick();
            if (sync_timeout) begin
                pulse_cnt++;
                if (pulse_cnt == 1) first_pulse = c;
                if (pulse_cnt == 2) second_pulse = c;
            end
            if (link_up) up_seen++;
        end
        check("timeout_first_cycle", first_pulse, 4096);
        check("timeout_second_cycle", second_pulse, 8192);
        check("timeout_pulse_count", pulse_cnt, 2);
        check("timeout_link_up", up_seen, 0);
        check("timeout_sync_req", sync_req, 1);

        // Bring-up: 16 cycles of lock then training in loopback
        apply_reset(1'b0);
        for (int c = 1; c <= 15; c++) tick();
        check("lock15_sync_req", sync_req, 1);
        check("lock15_datatx", datatx, 10'h000);
        tick();
        check("lock16_sync_req", sync_req, 0);
        check("lock16_datatx", datatx, 10'h2AA);
        for (int c = 1; c <= 7; c++) tick();
        check("train7_link_up", link_up, 0);
        tick();
        check("train8_link_up", link_up, 1);
        check("run_datatx_idle", datatx, 10'h000);

        // Loopback of one sample
        ad_voltage = 16'hA55A; ad_voltage_valid = 1'b1;
        tick();
        ad_voltage_valid = 1'b0;
        check("lb_capture_idle", datatx, 10'h000);
        tick();
        check("lb_high_word", datatx, 10'h2A5);
        tick();
        check("lb_low_word", datatx, 10'h15A);
        tick();
        check("lb_valid_early", rx_voltage_valid, 0);
        tick();
        check("lb_valid", rx_voltage_valid, 1);
        check("lb_rx_voltage", rx_voltage, 16'hA55A);
        tick();
        check("lb_valid_pulse", rx_voltage_valid, 0);
        check("lb_datatx_idle", datatx, 10'h000);
        check("lb_no_overrun", overrun, 0);

        // Overrun: second valid one cycle later, newest sample sent
        ad_voltage = 16'h1234; ad_voltage_valid = 1'b1;
        tick();
        ad_voltage = 16'hBEEF;
        tick();
        ad_voltage_valid = 1'b0;
        check("ovr_pulse", overrun, 1);
        check("ovr_high_word", datatx, 10'h2BE);
        tick();
        check("ovr_pulse_end", overrun, 0);
        check("ovr_low_word", datatx, 10'h1EF);
        check("ovr_count", overrun_cnt, EXP_OVR_1);
        tick();
        tick();
        check("ovr_rx_valid", rx_voltage_valid, 1);
        check("ovr_rx_voltage", rx_voltage, 16'hBEEF);
        check("ovr_no_frame_err", frame_err_cnt, 8'h00);

        // Deframer errors: low word without pending, then tag 2'b11
        loop_en = 1'b0; inj_word = 10'h111;
        tick();
        inj_word = 10'h000;
        tick();
        check("ferr_low_count", frame_err_cnt, EXP_ERR_1);
        check("ferr_low_no_valid", rx_voltage_valid, 0);
        tick();
        check("ferr_low_no_valid2", rx_voltage_valid, 0);
        inj_word = 10'h3FF;
        tick();
        inj_word = 10'h000;
        tick();
        check("ferr_tag11_count", frame_err_cnt, EXP_ERR_2);
        loop_en = 1'b1;
        tick();

        // Lock loss mid-sample in RUN
        ad_voltage = 16'h0F0F; ad_voltage_valid = 1'b1;
        tick();
        ad_voltage_valid = 1'b0;
        tick();
        check("lol_high_word", datatx, 10'h20F);
        lock_n = 1'b1;
        tick();
        check("lol_link_up", link_up, 0);
        check("lol_sync_req", sync_req, 1);
        check("lol_datatx", datatx, 10'h000);
        valid_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (rx_voltage_valid) valid_seen++;
            tick();
        end
        check("lol_no_rx_valid", valid_seen, 0);
        check("lol_overrun_cnt", overrun_cnt, EXP_OVR_1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
